sram_port_arbiter: RTL and testbench

Arbiter for the single-port synchronous SRAM shared by instruction fetch (PC stage) and data access (EX issue, MEM consume). It picks one requester per cycle, with data taking priority, and steers the 1-cycle-latency read data back to its owner. It holds each owner's last read word stable across pipeline stalls and raises a stall request so the losing fetch is re-issued. It sits between the pipeline stages and the SRAM and feeds the stall controller alongside the other `stallreq` sources.

---
 rtl/sram_port_arbiter_pkg.sv | 22 ++
 rtl/sram_port_arbiter.sv | 100 ++++++++++
 tb/tb_sram_port_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: stall bus layout and
// response-owner state encodings.
package sram_port_arbiter_pkg;

  localparam int STALL_W = 6;
  typedef logic [STALL_W-1:0] StallBus;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

  // Stall bus bit positions (PC=0, IF=1, ID=2, EX=3, MEM=4, WB=5)
  localparam int StallMem    = 4;
  localparam int StallreqArb = 6;

  typedef enum logic [1:0] {
    ARB_NONE    = 2'b00,
    ARB_RSP_I   = 2'b01,
    ARB_RSP_D   = 2'b10,
    ARB_RSP_D_W = 2'b11
  } arb_state_e;

endpackage

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: data beats fetch, 1-cycle read data is steered
// back to its owner and held between responses.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  StallBus           stall,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic [3:0]        data_wen,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              stallreq_arb,
  output logic [CNT_W-1:0]  conflict_cnt
);

  arb_state_e        state_q, state_d;
  logic [DATA_W-1:0] inst_hold_q, inst_hold_d;
  logic [DATA_W-1:0] data_hold_q, data_hold_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              conflict;
  logic              unused_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign unused_stall = ^{stall[STALL_W-1:StallMem+1], stall[StallMem-1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_NONE;
      inst_hold_q <= '0;
      data_hold_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      inst_hold_q <= inst_hold_d;
      data_hold_q <= data_hold_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d    = ARB_NONE;
    sram_en    = 1'b0;
    sram_wen   = 4'b0000;
    sram_addr  = '0;
    sram_wdata = '0;
    conflict   = inst_req & data_req;

    if (data_req) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
      // A stalled MEM cannot consume a new word, so a re-presented load
      // must not open a response that would overwrite the held one.
      if (data_wen == 4'b0000 && stall[StallMem] != Stop) begin
        state_d = inst_req ? ARB_RSP_D_W : ARB_RSP_D;
      end
    end else if (inst_req) begin
      sram_en   = 1'b1;
      sram_addr = inst_addr;
      state_d   = ARB_RSP_I;
    end

    if (!rst) begin
      sram_en    = 1'b0;
      sram_wen   = 4'b0000;
      sram_addr  = '0;
      sram_wdata = '0;
      conflict   = 1'b0;
    end

    stallreq_arb = conflict;
    cnt_d        = conflict ? sat_inc(cnt_q) : cnt_q;

    inst_rdata  = (state_q == ARB_RSP_I) ? sram_rdata : inst_hold_q;
    data_rdata  = (state_q == ARB_RSP_D || state_q == ARB_RSP_D_W) ? sram_rdata : data_hold_q;
    inst_hold_d = inst_rdata;
    data_hold_d = data_rdata;
  end

  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (counter built 4 bits wide so
// saturation is reachable).
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  StallBus           stall;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req;
  logic [3:0]        data_wen;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              stallreq_arb;
  logic [CNT_W-1:0]  conflict_cnt;

  int errors = 0;
  int checks = 0;
  int consec = 0;

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .stallreq_arb(stallreq_arb), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // Fetch may lose at most two consecutive cycles.
  always @(posedge clk) begin
    if (rst && inst_req && data_req) consec++;
    else consec = 0;
    assert (consec <= 2) else $error("protocol: %0d consecutive conflicts", consec);
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wen = 4'b0000;
    data_addr = '0; data_wdata = '0; stall = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); sram_rdata = 32'h5555_AAAA;
    inst_req = 1'b1; inst_addr = 32'h44; data_req = 1'b1; data_addr = 32'h88; data_wdata = 32'h1;
    #12;
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rst_en got=%0h exp=0", sram_en); end
    checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got=%0h exp=0", sram_addr); end
    checks++; if (sram_wdata !== 32'h0) begin errors++; $display("FAIL rst_wdata got=%0h exp=0", sram_wdata); end
    checks++; if (stallreq_arb !== 1'b0) begin errors++; $display("FAIL rst_stallreq got=%0h exp=0", stallreq_arb); end
    checks++; if (conflict_cnt !== 4'h0) begin errors++; $display("FAIL rst_cnt got=%0h exp=0", conflict_cnt); end
    checks++; if (inst_rdata !== 32'h0) begin errors++; $display("FAIL rst_irdata got=%0h exp=0", inst_rdata); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL rst_drdata got=%0h exp=0", data_rdata); end
    tick(); idle(); rst = 1'b1;
  endtask

  task automatic test_fetch();
    tick(); idle(); inst_req = 1'b1; inst_addr = 32'h0000_0010; #1;
    checks++; if (sram_en !== 1'b1) begin errors++; $display("FAIL fetch_en got=%0h exp=1", sram_en); end
    checks++; if (sram_wen !== 4'h0) begin errors++; $display("FAIL fetch_wen got=%0h exp=0", sram_wen); end
    checks++; if (sram_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr got=%0h exp=10", sram_addr); end
    checks++; if (stallreq_arb !== 1'b0) begin errors++; $display("FAIL fetch_stallreq got=%0h exp=0", stallreq_arb); end
    tick(); idle(); sram_rdata = 32'h2402_0005; #1;
    checks++; if (inst_rdata !== 32'h2402_0005) begin errors++; $display("FAIL fetch_rdata got=%0h exp=24020005", inst_rdata); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL fetch_drdata_untouched got=%0h exp=0", data_rdata); end
    tick(); sram_rdata = 32'h0BAD_F00D; #1;
    checks++; if (inst_rdata !== 32'h2402_0005) begin errors++; $display("FAIL fetch_hold got=%0h exp=24020005", inst_rdata); end
  endtask

  task automatic test_conflict();
    tick(); idle(); data_req = 1'b1; data_addr = 32'h100; inst_req = 1'b1; inst_addr = 32'h14; #1;
    checks++; if (sram_addr !== 32'h100) begin errors++; $display("FAIL conf_addr got=%0h exp=100", sram_addr); end
    checks++; if (stallreq_arb !== 1'b1) begin errors++; $display("FAIL conf_stallreq got=%0h exp=1", stallreq_arb); end
    tick(); data_req = 1'b0; data_addr = '0; sram_rdata = 32'hA5A5_0001; #1;
    checks++; if (data_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL conf_drdata got=%0h exp=a5a50001", data_rdata); end
    checks++; if (inst_rdata !== 32'h2402_0005) begin errors++; $display("FAIL conf_irdata_early got=%0h exp=24020005", inst_rdata); end
    checks++; if (sram_addr !== 32'h14) begin errors++; $display("FAIL conf_refetch_addr got=%0h exp=14", sram_addr); end
    checks++; if (stallreq_arb !== 1'b0) begin errors++; $display("FAIL conf_stallreq_clr got=%0h exp=0", stallreq_arb); end
    checks++; if (conflict_cnt !== 4'h1) begin errors++; $display("FAIL conf_cnt got=%0h exp=1", conflict_cnt); end
    tick(); idle(); sram_rdata = 32'h1111_2222; #1;
    checks++; if (inst_rdata !== 32'h1111_2222) begin errors++; $display("FAIL conf_irdata got=%0h exp=11112222", inst_rdata); end
    checks++; if (data_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL conf_dhold got=%0h exp=a5a50001", data_rdata); end
  endtask

  task automatic test_store();
    tick(); idle(); data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h200; data_wdata = 32'hDEAD_BEEF; #1;
    checks++; if (sram_en !== 1'b1) begin errors++; $display("FAIL st_en got=%0h exp=1", sram_en); end
    checks++; if (sram_wen !== 4'b0011) begin errors++; $display("FAIL st_wen got=%0h exp=3", sram_wen); end
    checks++; if (sram_addr !== 32'h200) begin errors++; $display("FAIL st_addr got=%0h exp=200", sram_addr); end
    checks++; if (sram_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL st_wdata got=%0h exp=deadbeef", sram_wdata); end
    tick(); idle(); sram_rdata = 32'h7777_7777; #1;
    checks++; if (data_rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL st_dhold got=%0h exp=a5a50001", data_rdata); end
    checks++; if (inst_rdata !== 32'h1111_2222) begin errors++; $display("FAIL st_ihold got=%0h exp=11112222", inst_rdata); end
  endtask

  task automatic test_stall_hold();
    tick(); idle(); data_req = 1'b1; data_addr = 32'h300;
    tick(); idle(); sram_rdata = 32'h1234_5678; #1;
    checks++; if (data_rdata !== 32'h1234_5678) begin errors++; $display("FAIL stl_load got=%0h exp=12345678", data_rdata); end
    for (int i = 0; i < 3; i++) begin
      tick(); stall[StallMem] = Stop; data_req = 1'b1; data_addr = 32'h300;
      sram_rdata = 32'hFFFF_0000 + i; #1;
      checks++; if (data_rdata !== 32'h1234_5678) begin errors++; $display("FAIL stl_hold%0d got=%0h exp=12345678", i, data_rdata); end
    end
    tick(); idle(); sram_rdata = 32'h0; #1;
    checks++; if (data_rdata !== 32'h1234_5678) begin errors++; $display("FAIL stl_after got=%0h exp=12345678", data_rdata); end
  endtask

  task automatic test_back_to_back();
    tick(); idle(); data_req = 1'b1; data_addr = 32'h400;
    tick(); data_addr = 32'h404; sram_rdata = 32'h0000_0A0A; #1;
    checks++; if (data_rdata !== 32'h0000_0A0A) begin errors++; $display("FAIL b2b_first got=%0h exp=a0a", data_rdata); end
    tick(); idle(); sram_rdata = 32'h0000_0B0B; #1;
    checks++; if (data_rdata !== 32'h0000_0B0B) begin errors++; $display("FAIL b2b_second got=%0h exp=b0b", data_rdata); end
    tick(); sram_rdata = 32'h0000_0C0C; #1;
    checks++; if (data_rdata !== 32'h0000_0B0B) begin errors++; $display("FAIL b2b_hold got=%0h exp=b0b", data_rdata); end
  endtask

  task automatic test_reset_mid();
    tick(); idle(); data_req = 1'b1; data_addr = 32'h500;
    tick(); idle(); rst = 1'b0; inst_req = 1'b1; inst_addr = 32'h60; sram_rdata = 32'hCAFE_F00D; #1;
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL rmid_drdata got=%0h exp=0", data_rdata); end
    checks++; if (inst_rdata !== 32'h0) begin errors++; $display("FAIL rmid_irdata got=%0h exp=0", inst_rdata); end
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rmid_en got=%0h exp=0", sram_en); end
    checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL rmid_addr got=%0h exp=0", sram_addr); end
    checks++; if (conflict_cnt !== 4'h0) begin errors++; $display("FAIL rmid_cnt got=%0h exp=0", conflict_cnt); end
    tick(); idle(); rst = 1'b1; sram_rdata = 32'hCAFE_F00D; #1;
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("FAIL rmid_stale got=%0h exp=0", data_rdata); end
  endtask

  task automatic test_saturation();
    int n = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); idle(); inst_req = 1'b1; inst_addr = 32'h80; data_req = 1'b1; data_addr = 32'h900;
      n++;
      if (k % 2 == 1) begin tick(); idle(); end
      else begin tick(); idle(); inst_req = 1'b1; inst_addr = 32'h80; end
      #1;
      checks++;
      if (conflict_cnt !== ((n > 15) ? 4'hF : 4'(n))) begin
        errors++; $display("FAIL sat_cnt%0d got=%0h exp=%0h", k, conflict_cnt, (n > 15) ? 4'hF : 4'(n));
      end
    end
    tick(); idle(); #1;
    checks++; if (conflict_cnt !== 4'hF) begin errors++; $display("FAIL sat_final got=%0h exp=f", conflict_cnt); end
  endtask

  initial begin
    idle(); rst = 1'b0; sram_rdata = '0;
    test_reset();
    test_fetch();
    test_conflict();
    test_store();
    test_stall_hold();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
